gs_elim_engine: RTL and testbench

Parametrised GF(2) Gaussian-elimination engine for the ROLLO decryption datapath; next generation of the controller + systolic-array elimination top. It loads a DAT_D x DAT_W binary matrix from a shared row memory, selected from MAT_CNT matrix slots. It reduces the matrix to row-echelon or reduced row-echelon form in one cycle per column, writes the result back in place and reports the rank.

---
 rtl/gs_elim_pkg.sv | 28 ++
 rtl/gs_elim_if.sv | 48 ++++
 rtl/gs_pivot_find.sv | 25 ++
 rtl/gs_elim_engine.sv | 179 +++++++++++++++++
 tb/tb_gs_elim_engine.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gs_elim_pkg.sv
// Shared definitions for the GF(2) Gaussian-elimination engine:
// FSM state encoding, memory read/write encoding and a constant clog2 helper.
package gs_elim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ELIM,
    STORE,
    DONE
  } state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/gs_elim_if.sv
// Control handshake and row-memory bus of the elimination engine.
// Optional macro GS_ELIM_PIVOT_OUT_EN adds the pivot-column side outputs.
interface gs_elim_if
  import gs_elim_pkg::*;
#(
  parameter int unsigned DAT_W   = 8,
  parameter int unsigned DAT_D   = 4,
  parameter int unsigned MAT_CNT = 1,
  parameter int unsigned AW      = clog2(DAT_D * MAT_CNT)
) ();

  localparam int unsigned SW  = (MAT_CNT > 1) ? clog2(MAT_CNT) : 1;
  localparam int unsigned RKW = clog2(DAT_D + 1);
  localparam int unsigned CLW = clog2(DAT_W);

  logic             start;
  logic             mode;
  logic [SW-1:0]    mat_sel;
  logic             busy;
  logic             done;
  logic [RKW-1:0]   rank;
  logic             full_rank;
  logic [DAT_W-1:0] mem_din;
  logic [DAT_W-1:0] mem_dout;
  logic [AW-1:0]    mem_addr;
  logic             mem_rw;
`ifdef GS_ELIM_PIVOT_OUT_EN
  logic             piv_valid;
  logic [CLW-1:0]   piv_col;
`endif

  modport slave (
    input  start, mode, mat_sel, mem_din,
    output busy, done, rank, full_rank, mem_dout, mem_addr, mem_rw
`ifdef GS_ELIM_PIVOT_OUT_EN
    , output piv_valid, piv_col
`endif
  );

  modport master (
    output start, mode, mat_sel, mem_din,
    input  busy, done, rank, full_rank, mem_dout, mem_addr, mem_rw
`ifdef GS_ELIM_PIVOT_OUT_EN
    , input piv_valid, piv_col
`endif
  );

endinterface

// File: rtl/gs_pivot_find.sv
// Masked priority encoder: lowest row index p >= r whose column bit is set.
module gs_pivot_find #(
  parameter int unsigned DAT_D = 4,
  parameter int unsigned RKW   = 3,
  parameter int unsigned PW    = 2
) (
  input  logic [DAT_D-1:0] col_bits,
  input  logic [RKW-1:0]   r,
  output logic             found,
  output logic [PW-1:0]    p
);

  // Scan from the top so the lowest qualifying index wins.
  always_comb begin
    found = 1'b0;
    p     = '0;
    for (int unsigned i = DAT_D; i > 0; i--) begin
      if (col_bits[i-1] && ((i - 1) >= 32'(r))) begin
        found = 1'b1;
        p     = PW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/gs_elim_engine.sv
// GF(2) Gaussian-elimination engine: loads a DAT_D x DAT_W bit matrix from a
// shared row memory, reduces it one column per cycle (row-echelon or reduced
// row-echelon), writes it back in place and reports the rank.
// Optional macro GS_ELIM_PIVOT_OUT_EN: pivot column per stored row.
module gs_elim_engine
  import gs_elim_pkg::*;
#(
  parameter int unsigned DAT_W      = 8,
  parameter int unsigned DAT_D      = 4,
  parameter int unsigned MAT_CNT    = 1,
  parameter int unsigned READ_DELAY = 2,
  parameter int unsigned AW         = clog2(DAT_D * MAT_CNT)
) (
  input logic       clk,
  input logic       rst_b,
  gs_elim_if.slave  bus
);

  localparam int unsigned RKW      = clog2(DAT_D + 1);
  localparam int unsigned CLW      = clog2(DAT_W);
  localparam int unsigned PW       = clog2(DAT_D);
  localparam int unsigned SW       = (MAT_CNT > 1) ? clog2(MAT_CNT) : 1;
  localparam int unsigned LOAD_LEN = DAT_D + READ_DELAY;
  localparam int unsigned CW       = clog2(LOAD_LEN);

  state_t           state, next;
  logic             mode_q;
  logic [SW-1:0]    sel_q;
  logic [CW-1:0]    cnt;
  logic [CLW-1:0]   col;
  logic [RKW-1:0]   r_cnt;
  logic [PW-1:0]    r_idx;
  logic [RKW-1:0]   rank_q;
  logic             full_q;
  logic [AW-1:0]    base;
  logic [DAT_W-1:0] rows      [DAT_D];
  logic [DAT_W-1:0] elim_rows [DAT_D];
  logic [DAT_D-1:0] col_bits;
  logic             found;
  logic [PW-1:0]    piv;
  logic             last_load, last_store, elim_exit;

  assign base       = AW'(32'(sel_q) * DAT_D);
  assign r_idx      = PW'(r_cnt);
  assign last_load  = (cnt == CW'(LOAD_LEN - 1));
  assign last_store = (cnt == CW'(DAT_D - 1));
  assign elim_exit  = (col == '0) || (found && (r_cnt == RKW'(DAT_D - 1)));

  gs_pivot_find #(.DAT_D(DAT_D), .RKW(RKW), .PW(PW)) u_pivot (
    .col_bits (col_bits),
    .r        (r_cnt),
    .found    (found),
    .p        (piv)
  );

  // Column slice under the current column pointer
  always_comb begin
    col_bits = '0;
    for (int unsigned i = 0; i < DAT_D; i++) col_bits[i] = rows[i][col];
  end

  // One elimination step: swap pivot into slot r, then clear column c elsewhere
  always_comb begin
    for (int unsigned i = 0; i < DAT_D; i++) elim_rows[i] = rows[i];
    if (found) begin
      elim_rows[r_idx] = rows[piv];
      elim_rows[piv]   = rows[r_idx];
      for (int unsigned i = 0; i < DAT_D; i++) begin
        if ((i != 32'(r_idx)) && elim_rows[i][col] && (mode_q || (i > 32'(r_idx))))
          elim_rows[i] = elim_rows[i] ^ rows[piv];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state <= IDLE;
    else       state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (bus.start) next = LOAD;
      LOAD:    if (last_load) next = ELIM;
      ELIM:    if (elim_exit) next = STORE;
      STORE:   if (last_store) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Datapath: request latching, counters, row buffer, rank result
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      mode_q <= 1'b0;
      sel_q  <= '0;
      cnt    <= '0;
      col    <= '0;
      r_cnt  <= '0;
      rank_q <= '0;
      full_q <= 1'b0;
      for (int unsigned i = 0; i < DAT_D; i++) rows[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          sel_q  <= bus.mat_sel;
          cnt    <= '0;
          col    <= CLW'(DAT_W - 1);
          r_cnt  <= '0;
        end
        LOAD: begin
          if (cnt >= CW'(READ_DELAY)) rows[PW'(cnt - CW'(READ_DELAY))] <= bus.mem_din;
          cnt <= last_load ? '0 : cnt + 1'b1;
        end
        ELIM: begin
          for (int unsigned i = 0; i < DAT_D; i++) rows[i] <= elim_rows[i];
          if (found) r_cnt <= r_cnt + 1'b1;
          col <= col - 1'b1;
        end
        STORE: begin
          cnt <= last_store ? '0 : cnt + 1'b1;
          if (last_store) begin
            rank_q <= r_cnt;
            full_q <= (r_cnt == RKW'(DAT_D));
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and counters
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.mem_rw   = MEM_RD;
    bus.mem_addr = '0;
    bus.mem_dout = '0;
    case (state)
      LOAD: begin
        if (cnt < CW'(DAT_D)) bus.mem_addr = base + AW'(cnt);
        else                  bus.mem_addr = base + AW'(DAT_D - 1);
      end
      ELIM, DONE: bus.mem_addr = base;
      STORE: begin
        bus.mem_rw   = MEM_WR;
        bus.mem_addr = base + AW'(cnt);
        bus.mem_dout = rows[PW'(cnt)];
      end
      default: ;
    endcase
  end

  assign bus.rank      = rank_q;
  assign bus.full_rank = full_q;

`ifdef GS_ELIM_PIVOT_OUT_EN
  logic [CLW-1:0] piv_cols [DAT_D];

  // Pivot column recorded per rank slot as each pivot is taken
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int unsigned i = 0; i < DAT_D; i++) piv_cols[i] <= '0;
    end else if ((state == ELIM) && found) begin
      piv_cols[r_idx] <= col;
    end
  end

  // Pivot report aligned with each STORE write of a ranked row
  always_comb begin
    bus.piv_valid = (state == STORE) && (32'(cnt) < 32'(r_cnt));
    bus.piv_col   = bus.piv_valid ? piv_cols[PW'(cnt)] : '0;
  end
`endif

endmodule

// File: tb/tb_gs_elim_engine.sv
// Directed bench for gs_elim_engine with a READ_DELAY-pipelined row memory.
module tb_gs_elim_engine;

  localparam int unsigned DAT_W      = 8;
  localparam int unsigned DAT_D      = 4;
  localparam int unsigned MAT_CNT    = 2;
  localparam int unsigned READ_DELAY = 2;
  localparam int unsigned AW         = 3;

  logic clk;
  logic rst_b;

  gs_elim_if #(.DAT_W(DAT_W), .DAT_D(DAT_D), .MAT_CNT(MAT_CNT), .AW(AW)) bus ();

  gs_elim_engine #(
    .DAT_W(DAT_W), .DAT_D(DAT_D), .MAT_CNT(MAT_CNT),
    .READ_DELAY(READ_DELAY), .AW(AW)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row memory: backdoor preload port, DUT write port, two-stage read pipe
  logic [7:0] mem  [8];
  logic [7:0] pipe [2];
  logic       pre_we;
  logic [2:0] pre_addr;
  logic [7:0] pre_data;
  int         oob_cnt;
  int unsigned win_lo;

  always @(posedge clk) begin
    if (pre_we)            mem[pre_addr]     <= pre_data;
    else if (bus.mem_rw)   mem[bus.mem_addr] <= bus.mem_dout;
    pipe[0] <= mem[bus.mem_addr];
    pipe[1] <= pipe[0];
  end
  assign bus.mem_din = pipe[1];

  initial oob_cnt = 0;
  always @(negedge clk) begin
    if (bus.busy === 1'b1 &&
        (32'(bus.mem_addr) < win_lo || 32'(bus.mem_addr) > win_lo + 3))
      oob_cnt <= oob_cnt + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int st_n;
  logic [7:0] st_addr [4];
  logic       st_pv   [4];
  logic [2:0] st_pc   [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    pre_addr = 3'(a);
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  task automatic load4(input int b, input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] r2, input logic [7:0] r3);
    poke(b, r0); poke(b + 1, r1); poke(b + 2, r2); poke(b + 3, r3);
  endtask

  task automatic kick(input logic md, input logic sel);
    bus.start   = 1'b1;
    bus.mode    = md;
    bus.mat_sel = sel;
    win_lo      = 32'(sel) * 4;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  // Start a run and wait (bounded) for done; returns cycles from start edge
  task automatic run(input logic md, input logic sel, output int lat);
    kick(md, sel);
    chk("busy_rise", 32'(bus.busy), 1);
    chk("first_addr", 32'(bus.mem_addr), 32'(sel) * 4);
    lat  = 1;
    st_n = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_rw === 1'b1 && st_n < 4) begin
        st_addr[st_n] = 8'(bus.mem_addr);
`ifdef GS_ELIM_PIVOT_OUT_EN
        st_pv[st_n] = bus.piv_valid;
        st_pc[st_n] = bus.piv_col;
`else
        st_pv[st_n] = 1'b0;
        st_pc[st_n] = '0;
`endif
        st_n++;
      end
    end
    chk("done_seen", 32'(bus.done), 1);
  endtask

  task automatic after_done;
    @(posedge clk); #1;
    chk("busy_fall", 32'(bus.busy), 0);
    chk("done_fall", 32'(bus.done), 0);
  endtask

  task automatic chk_mem(input string tag, input int b, input logic [7:0] r0,
                         input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    chk({tag, "_r0"}, 32'(mem[b]),     32'(r0));
    chk({tag, "_r1"}, 32'(mem[b + 1]), 32'(r1));
    chk({tag, "_r2"}, 32'(mem[b + 2]), 32'(r2));
    chk({tag, "_r3"}, 32'(mem[b + 3]), 32'(r3));
  endtask

  initial begin
    int lat;
    int done_cnt;
    int oob_before;
    rst_b       = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.mat_sel = 1'b0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    win_lo      = 0;
    st_n        = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      st_addr[i] = '0; st_pv[i] = 1'b0; st_pc[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rw", 32'(bus.mem_rw), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_dout", 32'(bus.mem_dout), 0);
    chk("rst_rank", 32'(bus.rank), 0);
    chk("rst_full", 32'(bus.full_rank), 0);
`ifdef GS_ELIM_PIVOT_OUT_EN
    chk("rst_piv_valid", 32'(bus.piv_valid), 0);
    chk("rst_piv_col", 32'(bus.piv_col), 0);
`endif
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Reduced mode, rank 2, worst-case latency
    load4(0, 8'h0F, 8'h0F, 8'hF0, 8'hFF);
    run(1'b1, 1'b0, lat);
    chk("a_latency", 32'(lat), 19);
    chk("a_rank", 32'(bus.rank), 2);
    chk("a_full", 32'(bus.full_rank), 0);
    chk_mem("a_mem", 0, 8'hF0, 8'h0F, 8'h00, 8'h00);
    chk("a_store_writes", 32'(st_n), 4);
    chk("a_store_addr3", 32'(st_addr[3]), 3);
`ifdef GS_ELIM_PIVOT_OUT_EN
    chk("a_pv0", 32'(st_pv[0]), 1);
    chk("a_pc0", 32'(st_pc[0]), 7);
    chk("a_pv1", 32'(st_pv[1]), 1);
    chk("a_pc1", 32'(st_pc[1]), 3);
    chk("a_pv2", 32'(st_pv[2]), 0);
    chk("a_pv3", 32'(st_pv[3]), 0);
`endif
    after_done();

    // Reduced vs echelon on the same matrix
    load4(0, 8'hC0, 8'h40, 8'h00, 8'h00);
    run(1'b1, 1'b0, lat);
    chk("b_red_rank", 32'(bus.rank), 2);
    chk_mem("b_red_mem", 0, 8'h80, 8'h40, 8'h00, 8'h00);
    after_done();
    load4(0, 8'hC0, 8'h40, 8'h00, 8'h00);
    run(1'b0, 1'b0, lat);
    chk("b_ech_rank", 32'(bus.rank), 2);
    chk_mem("b_ech_mem", 0, 8'hC0, 8'h40, 8'h00, 8'h00);
    after_done();

    // Full rank, early termination after 4 ELIM cycles
    load4(0, 8'h80, 8'h40, 8'h20, 8'h10);
    run(1'b1, 1'b0, lat);
    chk("c_latency", 32'(lat), 15);
    chk("c_rank", 32'(bus.rank), 4);
    chk("c_full", 32'(bus.full_rank), 1);
    chk_mem("c_mem", 0, 8'h80, 8'h40, 8'h20, 8'h10);
    after_done();

    // Reset mid-ELIM: outputs drop immediately, no done, results cleared
    load4(0, 8'h0F, 8'h0F, 8'hF0, 8'hFF);
    kick(1'b1, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    rst_b = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_rw", 32'(bus.mem_rw), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_rank", 32'(bus.rank), 0);
    chk("mid_rst_full", 32'(bus.full_rank), 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    done_cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 0);
    chk("mid_rst_mem_intact", 32'(mem[0]), 32'h0F);
    run(1'b1, 1'b0, lat);
    chk("rerun_latency", 32'(lat), 19);
    chk("rerun_rank", 32'(bus.rank), 2);
    chk_mem("rerun_mem", 0, 8'hF0, 8'h0F, 8'h00, 8'h00);
    after_done();

    // Slot 1 zero matrix: only addresses 4..7 touched, slot 0 intact
    load4(0, 8'h80, 8'h40, 8'h20, 8'h10);
    load4(4, 8'h00, 8'h00, 8'h00, 8'h00);
    oob_before = oob_cnt;
    run(1'b1, 1'b1, lat);
    chk("d_rank", 32'(bus.rank), 0);
    chk("d_full", 32'(bus.full_rank), 0);
    chk("d_store_addr0", 32'(st_addr[0]), 4);
    chk("d_store_addr3", 32'(st_addr[3]), 7);
    chk_mem("d_slot1", 4, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_mem("d_slot0", 0, 8'h80, 8'h40, 8'h20, 8'h10);
    after_done();
    chk("d_addr_window", 32'(oob_cnt - oob_before), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
